// File: rtl/clct_key_busy_gen.sv
// Per-key busy mask for the best-1-of-32 sorter: an accepted CLCT marks
// keys within +/-SPREAD of its key busy for a programmable dead time.
module clct_key_busy_gen #(
  parameter int MXKEY   = 32,
  parameter int MXKEYB  = 5,
  parameter int SPREAD  = 3,
  parameter int MXDEADB = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clct_vld,
  input  logic [MXKEYB-1:0]  clct_key,
  input  logic [MXDEADB-1:0] deadtime,
  input  logic               flush,
  output logic [MXKEY-1:0]   bsy,
  output logic               any_bsy,
  output logic               key_err
);

  // Two spare bits keep key+SPREAD and k+SPREAD from overflowing.
  localparam int KW = MXKEYB + 2;

  logic [MXDEADB-1:0] r_cnt     [MXKEY];
  logic [MXDEADB-1:0] w_cnt_nxt [MXKEY];
  logic [MXKEY-1:0]   w_bsy_nxt;
  logic [MXKEY-1:0]   r_bsy;
  logic               r_any;
  logic               r_kerr;
  logic [KW-1:0]      w_key;
  logic               w_kvalid;
  logic               w_load;
  logic               w_kerr_nxt;

  assign w_key      = KW'(clct_key);
  assign w_kvalid   = w_key < KW'(MXKEY);
  assign w_load     = clct_vld && w_kvalid && (deadtime != '0);
  assign w_kerr_nxt = clct_vld && !w_kvalid;

  // Window test k+SPREAD >= key && k <= key+SPREAD clips at both ends.
  always_comb begin
    w_bsy_nxt = '0;
    for (int k = 0; k < MXKEY; k++) begin
      w_cnt_nxt[k] = '0;
      if (flush) begin
        w_cnt_nxt[k] = '0;
      end else if (w_load &&
                   (KW'(k) + KW'(SPREAD) >= w_key) &&
                   (KW'(k) <= w_key + KW'(SPREAD))) begin
        w_cnt_nxt[k] = deadtime;
      end else if (r_cnt[k] != '0) begin
        w_cnt_nxt[k] = r_cnt[k] - 1'b1;
      end
      w_bsy_nxt[k] = (w_cnt_nxt[k] != '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MXKEY; k++) begin
        r_cnt[k] <= '0;
      end
      r_bsy  <= '0;
      r_any  <= 1'b0;
      r_kerr <= 1'b0;
    end else begin
      for (int k = 0; k < MXKEY; k++) begin
        r_cnt[k] <= w_cnt_nxt[k];
      end
      r_bsy  <= w_bsy_nxt;
      r_any  <= |w_bsy_nxt;
      r_kerr <= w_kerr_nxt;
    end
  end

  assign bsy     = r_bsy;
  assign any_bsy = r_any;
  assign key_err = r_kerr;

endmodule

// File: tb/tb_clct_key_busy_gen.sv
// Directed bench for clct_key_busy_gen: window load, edge clipping,
// overlap reload, flush, invalid key, deadtime 0 and async reset.
module tb_clct_key_busy_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clct_vld;
  logic [5:0]  clct_key;
  logic [3:0]  deadtime;
  logic        flush;
  logic [31:0] bsy;
  logic        any_bsy;
  logic        key_err;

  int checks = 0;
  int failures = 0;

  clct_key_busy_gen #(
    .MXKEY(32), .MXKEYB(6), .SPREAD(3), .MXDEADB(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clct_vld(clct_vld),
    .clct_key(clct_key), .deadtime(deadtime), .flush(flush),
    .bsy(bsy), .any_bsy(any_bsy), .key_err(key_err)
  );

  always #5 clock = ~clock;

  // Apply inputs at a falling edge, cross one rising edge, return at
  // the next falling edge where outputs are sampled.
  task automatic cyc(input logic v, input logic [5:0] k,
                     input logic [3:0] d, input logic f);
    clct_vld = v; clct_key = k; deadtime = d; flush = f;
    @(negedge clock);
    clct_vld = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 4'd0, 1'b0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clct_vld = 1'b0; clct_key = '0;
    deadtime = '0; flush = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bsy !== 32'h0 || any_bsy !== 1'b0 || key_err !== 1'b0) begin
      failures++;
      $display("FAIL reset bsy=%h any=%b err=%b want 0/0/0",
               bsy, any_bsy, key_err);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic;
    logic [31:0] exp [5];
    exp = '{32'h3F80, 32'h3F80, 32'h3F80, 32'h3F80, 32'h0};
    cyc(1'b1, 6'd10, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bsy !== exp[i] || any_bsy !== (exp[i] != 0)) begin
        failures++;
        $display("FAIL basic t+%0d bsy=%h any=%b want %h", i + 1,
                 bsy, any_bsy, exp[i]);
      end
      if (i < 4) idle(1);
    end
  endtask

  task automatic test_edge_clip;
    logic [31:0] exp [3];
    exp = '{32'h1F, 32'h1F, 32'h0};
    cyc(1'b1, 6'd1, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bsy !== exp[i]) begin
        failures++;
        $display("FAIL clip_lo t+%0d bsy=%h want %h", i + 1, bsy, exp[i]);
      end
      if (i < 2) idle(1);
    end
    exp = '{32'hF000_0000, 32'hF000_0000, 32'h0};
    cyc(1'b1, 6'd31, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bsy !== exp[i]) begin
        failures++;
        $display("FAIL clip_hi t+%0d bsy=%h want %h", i + 1, bsy, exp[i]);
      end
      if (i < 2) idle(1);
    end
  endtask

  // Key 10/dt 5 at t, key 12/dt 2 at t+2: overlap 9..13 reloads to 2.
  task automatic test_overlap;
    logic [31:0] exp [6];
    exp = '{32'h3F80, 32'h3F80, 32'hFF80, 32'hFF80, 32'h0180, 32'h0};
    cyc(1'b1, 6'd10, 4'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bsy !== exp[i] || any_bsy !== (exp[i] != 0)) begin
        failures++;
        $display("FAIL overlap t+%0d bsy=%h any=%b want %h", i + 1,
                 bsy, any_bsy, exp[i]);
      end
      if (i == 1) cyc(1'b1, 6'd12, 4'd2, 1'b0);
      else if (i < 5) idle(1);
    end
  endtask

  // Key 2/dt 3 then key 25/dt 3 on the next cycle.
  task automatic test_back_to_back;
    logic [31:0] exp [5];
    exp = '{32'h3F, 32'h1FC0_003F, 32'h1FC0_003F,
            32'h1FC0_0000, 32'h0};
    cyc(1'b1, 6'd2, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bsy !== exp[i]) begin
        failures++;
        $display("FAIL b2b t+%0d bsy=%h want %h", i + 1, bsy, exp[i]);
      end
      if (i == 0) cyc(1'b1, 6'd25, 4'd3, 1'b0);
      else if (i < 4) idle(1);
    end
  endtask

  task automatic test_flush;
    cyc(1'b1, 6'd10, 4'd8, 1'b0);
    idle(1);
    cyc(1'b1, 6'd20, 4'd5, 1'b1);
    checks++;
    if (bsy !== 32'h0 || any_bsy !== 1'b0) begin
      failures++;
      $display("FAIL flush_vld bsy=%h any=%b want 0", bsy, any_bsy);
    end
    idle(1);
    checks++;
    if (bsy !== 32'h0) begin
      failures++;
      $display("FAIL flush_noload bsy=%h want 0", bsy);
    end
    cyc(1'b1, 6'd10, 4'd8, 1'b0);
    checks++;
    if (bsy !== 32'h3F80) begin
      failures++;
      $display("FAIL flush_pre bsy=%h want 3f80", bsy);
    end
    cyc(1'b0, 6'd0, 4'd0, 1'b1);
    checks++;
    if (bsy !== 32'h0 || any_bsy !== 1'b0) begin
      failures++;
      $display("FAIL flush_alone bsy=%h any=%b want 0", bsy, any_bsy);
    end
    cyc(1'b1, 6'd40, 4'd3, 1'b1);
    checks++;
    if (key_err !== 1'b1 || bsy !== 32'h0) begin
      failures++;
      $display("FAIL flush_kerr err=%b bsy=%h want 1/0", key_err, bsy);
    end
    idle(1);
  endtask

  task automatic test_key_err;
    cyc(1'b1, 6'd10, 4'd4, 1'b0);
    cyc(1'b1, 6'd40, 4'd9, 1'b0);
    checks++;
    if (key_err !== 1'b1 || bsy !== 32'h3F80) begin
      failures++;
      $display("FAIL kerr_pulse err=%b bsy=%h want 1/3f80", key_err, bsy);
    end
    idle(1);
    checks++;
    if (key_err !== 1'b0 || bsy !== 32'h3F80) begin
      failures++;
      $display("FAIL kerr_end err=%b bsy=%h want 0/3f80", key_err, bsy);
    end
    idle(2);
    checks++;
    if (bsy !== 32'h0) begin
      failures++;
      $display("FAIL kerr_decay bsy=%h want 0", bsy);
    end
    cyc(1'b1, 6'd5, 4'd0, 1'b0);
    checks++;
    if (bsy !== 32'h0 || key_err !== 1'b0 || any_bsy !== 1'b0) begin
      failures++;
      $display("FAIL dt0 bsy=%h err=%b any=%b want 0", bsy, key_err,
               any_bsy);
    end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 6'd20, 4'd15, 1'b0);
    idle(2);
    checks++;
    if (bsy !== 32'h00FE_0000) begin
      failures++;
      $display("FAIL ares_pre bsy=%h want 00fe0000", bsy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bsy !== 32'h0 || any_bsy !== 1'b0) begin
      failures++;
      $display("FAIL ares_async bsy=%h any=%b want 0", bsy, any_bsy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    checks++;
    if (bsy !== 32'h0 || any_bsy !== 1'b0) begin
      failures++;
      $display("FAIL ares_hold bsy=%h any=%b want 0", bsy, any_bsy);
    end
    cyc(1'b1, 6'd0, 4'd1, 1'b0);
    checks++;
    if (bsy !== 32'hF || any_bsy !== 1'b1) begin
      failures++;
      $display("FAIL ares_next bsy=%h any=%b want f/1", bsy, any_bsy);
    end
    idle(1);
    checks++;
    if (bsy !== 32'h0) begin
      failures++;
      $display("FAIL ares_dt1 bsy=%h want 0", bsy);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edge_clip;
    test_overlap;
    test_back_to_back;
    test_flush;
    test_key_err;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
